// File: rtl/matmul_output_writer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_output_writer
// Description : Collects the skewed bottom outputs of a ROWS x COLS systolic
//               array into a row buffer, then writes the result matrix to RAM
//               one row at a time, holding each write for MEM_ACCESS_LATENCY
//               cycles. A four-phase done handshake uses fsm_done.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_output_writer #(
  parameter int          ROWS               = 4,
  parameter int          COLS               = 4,
  parameter int          WORD_SIZE          = 16,
  parameter int          MEM_ACCESS_LATENCY = 2,
  parameter logic [31:0] OUT_MAT_BASE_ADDR  = 32'h300,
  parameter int          MEM_ADDR_INCR      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COLS*WORD_SIZE-1:0] matmul_output,
  input  logic [COLS-1:0]           output_col_valid,
  input  logic                      fsm_done,
  output logic                      wr_output_rdy,
  output logic                      wr_output_done,
  output logic [31:0]               mem_addr,
  output logic                      mem_wr_en,
  output logic [COLS*WORD_SIZE-1:0] mem_wr_data,
  output logic                      err_overflow,
  output logic                      err_short
);

  localparam int c_DW    = COLS * WORD_SIZE;
  localparam int c_CNT_W = $clog2(ROWS + 1);
  localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_LAT_W = (MEM_ACCESS_LATENCY > 1) ? $clog2(MEM_ACCESS_LATENCY) : 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_CAPTURE = 2'd1;
  localparam logic [1:0] c_WRITE   = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;

  logic [c_DW-1:0]     r_buf      [ROWS];
  logic [c_DW-1:0]     w_buf_next [ROWS];
  logic [c_CNT_W-1:0]  r_col_cnt  [COLS];
  logic [c_CNT_W-1:0]  w_cnt_next [COLS];

  logic                w_capturing;
  logic                w_any_valid;
  logic                w_ovf;
  logic                w_short;
  logic                w_enter_idle;
  logic                w_clear_err;

  logic [c_ROW_W-1:0]  r_row;
  logic [c_ROW_W-1:0]  w_row_inc;
  logic [c_LAT_W-1:0]  r_lat;
  logic                w_lat_end;
  logic                w_row_end;

  logic [31:0]         r_mem_addr;
  logic                r_mem_wr_en;
  logic [c_DW-1:0]     r_mem_wr_data;
  logic                r_err_ovf;
  logic                r_err_short;

  assign w_capturing  = (r_state == c_IDLE) || (r_state == c_CAPTURE);
  assign w_any_valid  = |output_col_valid;
  assign w_enter_idle = (r_state == c_DONE) && !fsm_done;
  assign w_clear_err  = (r_state == c_IDLE) && (w_next_state == c_CAPTURE);
  assign w_lat_end    = (r_lat == c_LAT_W'(MEM_ACCESS_LATENCY - 1));
  assign w_row_end    = (r_row == c_ROW_W'(ROWS - 1));
  assign w_row_inc    = r_row + c_ROW_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; fsm_done takes priority over a first valid beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (fsm_done)         w_next_state = c_WRITE;
        else if (w_any_valid) w_next_state = c_CAPTURE;
      end
      c_CAPTURE: if (fsm_done)              w_next_state = c_WRITE;
      c_WRITE:   if (w_lat_end && w_row_end) w_next_state = c_DONE;
      c_DONE:    if (!fsm_done)             w_next_state = c_IDLE;
      default:                              w_next_state = c_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    wr_output_rdy  = (r_state == c_IDLE);
    wr_output_done = (r_state == c_DONE);
  end

  // Buffer and counters as they will be after this cycle's capture.
  always_comb begin
    w_buf_next = r_buf;
    w_cnt_next = r_col_cnt;
    w_ovf      = 1'b0;
    if (w_capturing) begin
      for (int c = 0; c < COLS; c++) begin
        if (output_col_valid[c]) begin
          if (r_col_cnt[c] == c_CNT_W'(ROWS)) begin
            w_ovf = 1'b1;
          end else begin
            for (int r = 0; r < ROWS; r++) begin
              if (r_col_cnt[c] == c_CNT_W'(r))
                w_buf_next[r][c*WORD_SIZE +: WORD_SIZE] = matmul_output[c*WORD_SIZE +: WORD_SIZE];
            end
            w_cnt_next[c] = r_col_cnt[c] + c_CNT_W'(1);
          end
        end
      end
    end
  end

  // Any column still short of ROWS words once this cycle's beat is in.
  always_comb begin
    w_short = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (w_cnt_next[c] < c_CNT_W'(ROWS)) w_short = 1'b1;
    end
  end

  // Capture buffer; wiped on reset and whenever the writer returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst || w_enter_idle) begin
      for (int r = 0; r < ROWS; r++) r_buf[r] <= '0;
      for (int c = 0; c < COLS; c++) r_col_cnt[c] <= '0;
    end else if (w_capturing) begin
      r_buf     <= w_buf_next;
      r_col_cnt <= w_cnt_next;
    end
  end

  // Sticky error flags, cleared only when a new capture begins from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_ovf   <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      r_err_ovf   <= (w_clear_err ? 1'b0 : r_err_ovf) | (w_capturing & w_ovf);
      r_err_short <= (w_clear_err ? 1'b0 : r_err_short) | (w_capturing & fsm_done & w_short);
    end
  end

  // Row write sequencer: row 0 is loaded from the post-capture buffer so a
  // beat arriving with fsm_done is part of the written result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr    <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_data <= '0;
      r_row         <= '0;
      r_lat         <= '0;
    end else if (w_capturing && fsm_done) begin
      r_mem_addr    <= OUT_MAT_BASE_ADDR;
      r_mem_wr_en   <= 1'b1;
      r_mem_wr_data <= w_buf_next[0];
      r_row         <= '0;
      r_lat         <= '0;
    end else if (r_state == c_WRITE) begin
      if (w_lat_end) begin
        r_lat <= '0;
        if (w_row_end) begin
          r_mem_wr_en <= 1'b0;
        end else begin
          r_row         <= w_row_inc;
          r_mem_addr    <= r_mem_addr + 32'(MEM_ADDR_INCR);
          r_mem_wr_data <= r_buf[w_row_inc];
        end
      end else begin
        r_lat <= r_lat + c_LAT_W'(1);
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wr_en    = r_mem_wr_en;
  assign mem_wr_data  = r_mem_wr_data;
  assign err_overflow = r_err_ovf;
  assign err_short    = r_err_short;

endmodule
`default_nettype wire

// File: tb/tb_matmul_output_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_output_writer
// Description : Self-checking bench for matmul_output_writer (2x2 array).
//               A per-column list model predicts RAM rows and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_output_writer;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int W    = 16;
  localparam int LAT  = 2;
  localparam logic [31:0] BASE = 32'h300;
  localparam int INCR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [COLS*W-1:0] matmul_output;
  logic [COLS-1:0]   output_col_valid;
  logic              fsm_done;
  logic              wr_output_rdy;
  logic              wr_output_done;
  logic [31:0]       mem_addr;
  logic              mem_wr_en;
  logic [COLS*W-1:0] mem_wr_data;
  logic              err_overflow;
  logic              err_short;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus for one matmul: one entry per cycle, last entry carries fsm_done.
  logic [COLS-1:0]   q_valid [$];
  logic [COLS*W-1:0] q_data  [$];

  // Reference model state.
  int          m_cnt   [COLS];
  logic [W-1:0] m_words [ROWS][COLS];
  bit          exp_ovf;
  bit          exp_short;

  matmul_output_writer #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(W), .MEM_ACCESS_LATENCY(LAT),
    .OUT_MAT_BASE_ADDR(BASE), .MEM_ADDR_INCR(INCR)
  ) dut (
    .clk(clk), .rst(rst), .matmul_output(matmul_output),
    .output_col_valid(output_col_valid), .fsm_done(fsm_done),
    .wr_output_rdy(wr_output_rdy), .wr_output_done(wr_output_done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .err_overflow(err_overflow), .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [COLS-1:0] v, input logic [W-1:0] d1, input logic [W-1:0] d0);
    q_valid.push_back(v);
    q_data.push_back({d1, d0});
  endtask

  function automatic logic [COLS*W-1:0] exp_row(input int r);
    logic [COLS*W-1:0] row;
    for (int c = 0; c < COLS; c++) row[c*W +: W] = m_words[r][c];
    return row;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) m_cnt[c] = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_words[r][c] = '0;
  endtask

  // Drives the queued beats; after return the DUT sits in its first write cycle.
  task automatic drive_phase();
    int n;
    bit seen;
    logic [COLS*W-1:0] d;
    n = q_valid.size();
    seen = 0;
    model_clear();
    for (int i = 0; i < n; i++) begin
      d = q_data[i];
      output_col_valid = q_valid[i];
      matmul_output    = d;
      fsm_done         = (i == n - 1);
      if (q_valid[i] != 0 && !seen) begin
        seen = 1;
        if (i < n - 1) begin
          exp_ovf   = 0;
          exp_short = 0;
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (q_valid[i][c]) begin
          if (m_cnt[c] == ROWS) exp_ovf = 1;
          else begin
            m_words[m_cnt[c]][c] = d[c*W +: W];
            m_cnt[c]++;
          end
        end
      end
      if (i == n - 1)
        for (int c = 0; c < COLS; c++) if (m_cnt[c] < ROWS) exp_short = 1;
      tick();
      if (i < n - 1) check("rdy_capture", wr_output_rdy, !seen);
    end
    q_valid.delete();
    q_data.delete();
  endtask

  task automatic run_matmul(input int hold);
    logic [31:0] last_addr;
    drive_phase();
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < LAT; l++) begin
        check("wr_en", mem_wr_en, 1);
        check("addr", mem_addr, BASE + 32'(r * INCR));
        check("data", mem_wr_data, exp_row(r));
        check("done_early", wr_output_done, 0);
        output_col_valid = COLS'($urandom);
        matmul_output    = (COLS*W)'($urandom);
        tick();
      end
    end
    last_addr = BASE + 32'((ROWS - 1) * INCR);
    for (int k = 0; k <= hold; k++) begin
      check("done", wr_output_done, 1);
      check("en_off", mem_wr_en, 0);
      check("rdy_done", wr_output_rdy, 0);
      check("addr_hold", mem_addr, last_addr);
      check("data_hold", mem_wr_data, exp_row(ROWS - 1));
      check("err_ovf", err_overflow, exp_ovf);
      check("err_short", err_short, exp_short);
      output_col_valid = COLS'($urandom);
      tick();
    end
    fsm_done = 0;
    output_col_valid = '0;
    tick();
    check("done_drop", wr_output_done, 0);
    check("rdy_idle", wr_output_rdy, 1);
  endtask

  initial begin
    rst = 1;
    matmul_output = '0;
    output_col_valid = '0;
    fsm_done = 0;
    exp_ovf = 0;
    exp_short = 0;
    tick();
    tick();
    check("rst_rdy", wr_output_rdy, 1);
    check("rst_done", wr_output_done, 0);
    check("rst_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_ovf", err_overflow, 0);
    check("rst_short", err_short, 0);
    rst = 0;
    tick();

    // Skewed capture.
    push(2'b01, 0, 1); push(2'b11, 3, 2); push(2'b10, 4, 0); push(2'b00, 0, 0);
    run_matmul(2);
    // Overflow on column 0.
    push(2'b11, 8, 5); push(2'b11, 9, 6); push(2'b01, 0, 7); push(2'b00, 0, 0);
    run_matmul(1);
    // Short: a single column-0 beat.
    push(2'b01, 0, 1); push(2'b00, 0, 0);
    run_matmul(0);
    // Final beat arrives together with fsm_done.
    push(2'b11, 2, 1); push(2'b01, 0, 3); push(2'b10, 4, 0);
    run_matmul(1);

    // Reset during the second row write.
    push(2'b11, 22, 21); push(2'b11, 24, 23); push(2'b00, 0, 0);
    drive_phase();
    for (int k = 0; k < LAT + 1; k++) tick();
    check("row1_en", mem_wr_en, 1);
    check("row1_addr", mem_addr, BASE + 32'(INCR));
    rst = 1;
    fsm_done = 0;
    tick();
    check("midrst_en", mem_wr_en, 0);
    check("midrst_rdy", wr_output_rdy, 1);
    check("midrst_done", wr_output_done, 0);
    rst = 0;
    exp_ovf = 0;
    exp_short = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("postrst_done", wr_output_done, 0);
      check("postrst_en", mem_wr_en, 0);
    end

    // Back-to-back fresh run.
    push(2'b11, 11, 9); push(2'b11, 12, 10); push(2'b00, 0, 0);
    run_matmul(0);

    // Randomized runs.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        push(COLS'($urandom), W'($urandom), W'($urandom));
      run_matmul($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_output_writer.md
MATMUL_OUTPUT_WRITER -- requirements
Module: matmul_output_writer

Interface
REQ-001 Parameter ROWS, default 4: systolic array rows; number of outputs captured per column.
REQ-002 Parameter COLS, default 4: systolic array columns.
REQ-003 Parameter WORD_SIZE, default 16: bits per output word.
REQ-004 Parameter MEM_ACCESS_LATENCY, default 2: clk cycles each RAM write is held.
REQ-005 Parameter OUT_MAT_BASE_ADDR, default 32'h300: RAM address of output row 0.
REQ-006 Parameter MEM_ADDR_INCR, default 4: address step between output rows.
REQ-007 Reset rst, synchronous, active-high; clock clk.
REQ-008 Port list (name, direction, width, meaning), one line each:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- matmul_output  in  COLS*WORD_SIZE  bottom_out of array; column c at bits [c*WORD_SIZE +: WORD_SIZE].
- output_col_valid  in  COLS  bit c high: column c word valid this cycle.
- fsm_done  in  1  matmul controller finished producing outputs.
- wr_output_rdy  out  1  writer idle, buffer empty, may accept a new matmul.
- wr_output_done  out  1  all rows written to RAM.
- mem_addr  out  32  RAM write address.
- mem_wr_en  out  1  RAM write enable.
- mem_wr_data  out  COLS*WORD_SIZE  RAM write data, one output row.
- err_overflow  out  1  sticky: a valid beat arrived for a column already holding ROWS words.
- err_short  out  1  sticky: fsm_done seen while some column held fewer than ROWS words.

Function
REQ-009 State machine states IDLE, CAPTURE, WRITE, DONE; all sampling on posedge clk.
REQ-010 Buffer ROWS x COLS words plus per-column counter col_cnt[c] (0..ROWS); counters and buffer cleared on entry to IDLE.
REQ-011 Capture in IDLE and CAPTURE: for each c with output_col_valid[c]=1 and col_cnt[c]<ROWS, buf[col_cnt[c]][c] <= column c word, col_cnt[c]++; independent per column, multiple columns same cycle all captured.
REQ-012 Valid beat with col_cnt[c]==ROWS: word dropped, err_overflow <= 1.
REQ-013 IDLE: wr_output_rdy=1; any output_col_valid bit high -> CAPTURE (beat captured that cycle), wr_output_rdy=0 from next cycle.
REQ-014 IDLE or CAPTURE with fsm_done=1 -> WRITE next cycle; valid beats in that same cycle still captured; if any col_cnt (after that cycle's capture) < ROWS, err_short <= 1; missing entries written as zero.
REQ-015 WRITE: rows r = 0..ROWS-1 in order; each row: mem_addr = OUT_MAT_BASE_ADDR + r*MEM_ADDR_INCR, mem_wr_data = buf[r], mem_wr_en=1, all held exactly MEM_ACCESS_LATENCY cycles; next row follows with no gap.
REQ-016 Write phase lasts exactly ROWS*MEM_ACCESS_LATENCY cycles; output_col_valid ignored during WRITE and DONE.
REQ-017 After last row: mem_wr_en=0, mem_addr/mem_wr_data hold last values, -> DONE.
REQ-018 DONE: wr_output_done=1; held until fsm_done sampled 0, then -> IDLE with wr_output_done=0, wr_output_rdy=1 next cycle (four-phase handshake).
REQ-019 Address arithmetic 32-bit, wraps modulo 2^32.
REQ-020 err_overflow/err_short cleared only by rst or on IDLE->CAPTURE transition.

Reset
REQ-021 rst=1: state IDLE, wr_output_rdy=1, wr_output_done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, err flags 0, counters 0, buffer 0.
REQ-022 rst mid-WRITE: mem_wr_en=0 next cycle, partial row never re-issued, no wr_output_done.

Verification (ROWS=COLS=2, WORD_SIZE=16, LATENCY=2, base 0x300, incr 4)
REQ-023 Skewed capture: col0 valid 1,2 cycles t,t+1; col1 valid 3,4 cycles t+1,t+2; fsm_done t+3 -> writes {col1=3,col0=1} @0x300 for 2 cycles, then {4,2} @0x304 for 2 cycles; wr_output_done held until fsm_done drops; no errors.
REQ-024 Overflow: col0 valid 3 beats (5,6,7) -> 7 dropped, err_overflow=1, row data still 5,6.
REQ-025 Short: fsm_done after one col0 beat only -> err_short=1, row1 and col1 written as 0.
REQ-026 Simultaneous: final col1 beat and fsm_done same cycle -> beat captured, err_short=0.
REQ-027 Reset during second row write -> mem_wr_en=0, wr_output_rdy=1 next cycle, wr_output_done never asserted.
REQ-028 Back-to-back: after DONE->IDLE, second matmul with values 9..12 writes fresh data; no residue from first run.
